// File: rtl/reg_bank_arb_pkg.sv
// Shared constants and the FSM state type for the register bank arbiter.
// Imported by the arbiter top and its round-robin helper.
package reg_bank_arb_pkg;

    localparam int unsigned REG_ADDR_W = 3;
    localparam int unsigned REG_DATA_W = 8;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin winner select. Purely combinational; the caller owns last_grant.
module rr_arb2
    import reg_bank_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic valid,
    output logic winner
);

    always_comb begin
        valid  = req0 | req1;
        winner = REQ0;
        // On a tie the requester that did not win last time goes first.
        if (req0 && req1) begin
            winner = ~last_grant;
        end else if (req1) begin
            winner = REQ1;
        end
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Serialises single read/write transactions from two requesters onto the register bank port.
// Every output is a flop; read data is returned with a one-cycle rvalid pulse.
module reg_bank_arbiter
    import reg_bank_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = REG_ADDR_W,
    parameter int unsigned DATA_W = REG_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic              reg_en,
    output logic              reg_we,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              busy
);

    state_t state_q, state_d;
    logic   last_q, last_d;
    logic   win_q, win_d;

    logic              gnt0_d, gnt1_d, rvalid0_d, rvalid1_d;
    logic              reg_en_d, reg_we_d, busy_d;
    logic [ADDR_W-1:0] reg_addr_d;
    logic [DATA_W-1:0] reg_wdata_d, rdata0_d, rdata1_d;

    logic arb_valid, arb_winner;

    rr_arb2 u_rr_arb2 (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_q),
        .valid      (arb_valid),
        .winner     (arb_winner)
    );

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        win_d       = win_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        rvalid0_d   = 1'b0;
        rvalid1_d   = 1'b0;
        reg_en_d    = 1'b0;
        reg_we_d    = 1'b0;
        reg_addr_d  = '0;
        reg_wdata_d = '0;
        rdata0_d    = rdata0;
        rdata1_d    = rdata1;

        unique case (state_q)
            S_IDLE: begin
                if (arb_valid) begin
                    // The reg_* flops double as the latched command for the access cycle.
                    state_d     = S_ACCESS;
                    last_d      = arb_winner;
                    win_d       = arb_winner;
                    reg_en_d    = 1'b1;
                    if (arb_winner == REQ1) begin
                        gnt1_d      = 1'b1;
                        reg_we_d    = we1;
                        reg_addr_d  = addr1;
                        reg_wdata_d = wdata1;
                    end else begin
                        gnt0_d      = 1'b1;
                        reg_we_d    = we0;
                        reg_addr_d  = addr0;
                        reg_wdata_d = wdata0;
                    end
                end
            end
            S_ACCESS: begin
                state_d = reg_we ? S_IDLE : S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
                if (win_q == REQ1) begin
                    rvalid1_d = 1'b1;
                    rdata1_d  = reg_rdata;
                end else begin
                    rvalid0_d = 1'b1;
                    rdata0_d  = reg_rdata;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            last_q    <= REQ1;
            win_q     <= REQ0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            reg_en    <= 1'b0;
            reg_we    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            win_q     <= win_d;
            gnt0      <= gnt0_d;
            gnt1      <= gnt1_d;
            rvalid0   <= rvalid0_d;
            rvalid1   <= rvalid1_d;
            rdata0    <= rdata0_d;
            rdata1    <= rdata1_d;
            reg_en    <= reg_en_d;
            reg_we    <= reg_we_d;
            reg_addr  <= reg_addr_d;
            reg_wdata <= reg_wdata_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter with a simple behavioural register bank on the far side.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_reg_bank_arbiter;

    logic       clk, rst_n;
    logic       req0, we0, gnt0, rvalid0;
    logic [2:0] addr0;
    logic [7:0] wdata0, rdata0;
    logic       req1, we1, gnt1, rvalid1;
    logic [2:0] addr1;
    logic [7:0] wdata1, rdata1;
    logic       reg_en, reg_we, busy;
    logic [2:0] reg_addr;
    logic [7:0] reg_wdata, reg_rdata;

    logic [7:0] bank [8];
    logic [7:0] exp_mem [8];
    int total = 0;
    int bad = 0;

    reg_bank_arbiter #(.ADDR_W(3), .DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .we0       (we0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .gnt0      (gnt0),
        .rvalid0   (rvalid0),
        .rdata0    (rdata0),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .gnt1      (gnt1),
        .rvalid1   (rvalid1),
        .rdata1    (rdata1),
        .reg_en    (reg_en),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register bank: synchronous write, read data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (reg_en) begin
            if (reg_we) bank[reg_addr] <= reg_wdata;
            else        reg_rdata      <= bank[reg_addr];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete transaction from an idle arbiter; checks the bank command and read data.
    task automatic txn(input logic r, input logic w, input logic [2:0] a, input logic [7:0] d);
        int n;
        logic g, rv;
        logic [7:0] rd;
        if (r) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
        else   begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
        n = 0;
        do begin
            @(negedge clk);
            n++;
            g = r ? gnt1 : gnt0;
        end while (!g && n < 10);
        chk("txn_gnt", 32'(g), 32'd1);
        chk("txn_gnt_lat", 32'(n), 32'd1);
        chk("txn_reg_en", 32'(reg_en), 32'd1);
        chk("txn_reg_we", 32'(reg_we), 32'(w));
        chk("txn_reg_addr", 32'(reg_addr), 32'(a));
        if (w) chk("txn_reg_wdata", 32'(reg_wdata), 32'(d));
        req0 = 1'b0;
        req1 = 1'b0;
        if (w) begin
            exp_mem[a] = d;
            @(negedge clk);
            chk("txn_wr_idle", 32'(busy), 32'd0);
        end else begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
                rv = r ? rvalid1 : rvalid0;
            end while (!rv && n < 5);
            rd = r ? rdata1 : rdata0;
            chk("txn_rvalid", 32'(rv), 32'd1);
            chk("txn_rd_lat", 32'(n), 32'd2);
            chk("txn_rdata", 32'(rd), 32'(exp_mem[a]));
        end
    endtask

    initial begin
        int n, g1, ngnt, nrv, ngall, i0, i1, lastg, mingap;
        logic both, rvseen;
        logic order [4];

        // 1: reset with both requesting
        rst_n = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 3'd0; wdata0 = 8'h11;
        req1 = 1'b1; we1 = 1'b1; addr1 = 3'd1; wdata1 = 8'h22;
        repeat (3) @(negedge clk);
        chk("rst_gnt0", 32'(gnt0), 32'd0);
        chk("rst_gnt1", 32'(gnt1), 32'd0);
        chk("rst_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
        chk("rst_reg_en", 32'(reg_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdata", 32'({rdata0, rdata1}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_gnt0", 32'(gnt0), 32'd1);
        chk("first_gnt1", 32'(gnt1), 32'd0);
        chk("first_busy", 32'(busy), 32'd1);
        req0 = 1'b0;
        req1 = 1'b0;
        exp_mem[0] = 8'h11;
        @(negedge clk);

        // 2: write then read, requester 0
        txn(1'b0, 1'b1, 3'd3, 8'hA5);
        txn(1'b0, 1'b0, 3'd3, 8'h00);
        chk("rd_rdata1_unchanged", 32'(rdata1), 32'd0);
        @(negedge clk);
        chk("rvalid0_pulse", 32'(rvalid0), 32'd0);
        txn(1'b1, 1'b1, 3'd5, 8'h5A);

        // 3: tie fairness over four reads
        we0 = 1'b0; addr0 = 3'd3; we1 = 1'b0; addr1 = 3'd5;
        req0 = 1'b1; req1 = 1'b1;
        ngnt = 0; ngall = 0; nrv = 0; both = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (gnt0 && gnt1) both = 1'b1;
            if (rvalid0 && rvalid1) both = 1'b1;
            if (gnt0 || gnt1) begin
                ngall++;
                if (ngnt < 4) begin
                    order[ngnt] = gnt1;
                    ngnt++;
                    if (ngnt == 4) begin req0 = 1'b0; req1 = 1'b0; end
                end
            end
            if (rvalid0) begin nrv++; chk("tie_rdata0", 32'(rdata0), 32'h A5); end
            if (rvalid1) begin nrv++; chk("tie_rdata1", 32'(rdata1), 32'h5A); end
        end
        chk("tie_order0", 32'(order[0]), 32'd0);
        chk("tie_order1", 32'(order[1]), 32'd1);
        chk("tie_order2", 32'(order[2]), 32'd0);
        chk("tie_order3", 32'(order[3]), 32'd1);
        chk("tie_ngnt", 32'(ngall), 32'd4);
        chk("tie_nrv", 32'(nrv), 32'd4);
        chk("tie_never_both", 32'(both), 32'd0);

        // 4: starvation bound with req1 held
        we1 = 1'b1; addr1 = 3'd6; wdata1 = 8'h66; req1 = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!gnt1 && n < 10);
        chk("starve_gnt1", 32'(gnt1), 32'd1);
        we0 = 1'b0; addr0 = 3'd6; req0 = 1'b1;
        n = 0; g1 = 0;
        do begin
            @(negedge clk);
            n++;
            if (gnt1) g1++;
        end while (!gnt0 && n < 10);
        chk("starve_gnt0", 32'(gnt0), 32'd1);
        chk("starve_lat", 32'(n), 32'd2);
        chk("starve_no_gnt1", 32'(g1), 32'd0);
        req0 = 1'b0; req1 = 1'b0;
        exp_mem[6] = 8'h66;
        n = 0;
        do begin @(negedge clk); n++; end while (!rvalid0 && n < 5);
        chk("starve_rvalid0", 32'(rvalid0), 32'd1);
        chk("starve_rdata0", 32'(rdata0), 32'h66);

        // 5: reset pulse while a read sits in RESP
        we0 = 1'b0; addr0 = 3'd3; req0 = 1'b1;
        @(negedge clk);
        chk("rstmid_gnt0", 32'(gnt0), 32'd1);
        req0 = 1'b0;
        @(negedge clk);
        chk("rstmid_busy_resp", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_rdata0", 32'(rdata0), 32'd0);
        #2;
        rst_n = 1'b1;
        rvseen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rvalid0 || rvalid1 || busy) rvseen = 1'b1;
        end
        chk("rstmid_quiet", 32'(rvseen), 32'd0);
        txn(1'b1, 1'b1, 3'd7, 8'h3C);
        txn(1'b0, 1'b0, 3'd7, 8'h00);

        // 6: back-to-back write sweep, then full read-back from both sides
        i0 = 0; i1 = 0; lastg = -100; mingap = 100;
        we0 = 1'b1; addr0 = 3'd0; wdata0 = 8'($urandom);
        we1 = 1'b1; addr1 = 3'd4; wdata1 = 8'($urandom);
        req0 = 1'b1; req1 = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                if (c - lastg < mingap) mingap = c - lastg;
                lastg = c;
            end
            if (gnt0) begin
                exp_mem[addr0] = wdata0;
                i0++;
                if (i0 == 4) req0 = 1'b0;
                else begin addr0 = 3'(i0); wdata0 = 8'($urandom); end
            end
            if (gnt1) begin
                exp_mem[addr1] = wdata1;
                i1++;
                if (i1 == 4) req1 = 1'b0;
                else begin addr1 = 3'(4 + i1); wdata1 = 8'($urandom); end
            end
        end
        chk("sweep_writes0", 32'(i0), 32'd4);
        chk("sweep_writes1", 32'(i1), 32'd4);
        chk("sweep_min_gap", 32'(mingap), 32'd2);
        for (int a = 0; a < 8; a++) begin
            txn(1'b0, 1'b0, 3'(a), 8'h00);
            txn(1'b1, 1'b0, 3'(a), 8'h00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
